// File: rtl/instruction_decoder_pipe_pkg.sv
// Shared definitions for the 8-bit CPU instruction decoder: opcode classes,
// data-bus source codes, register-enable bit positions and NOP encodings.
package instruction_decoder_pipe_pkg;

    typedef enum logic [2:0] {
        CLS_LOAD   = 3'd0,   // 0ddd_nnnn
        CLS_MOVE   = 3'd1,   // 10dd_dsss
        CLS_ALU    = 3'd2,   // 110x_yfff
        CLS_JMP    = 3'd3,   // 1110_aaaa
        CLS_JMP_NZ = 3'd4    // 1111_aaaa
    } instr_class_e;

    // Data-bus source select codes
    localparam logic [3:0] SRC_R     = 4'd4;
    localparam logic [3:0] SRC_IMM   = 4'd8;
    localparam logic [3:0] SRC_IPINS = 4'd9;
    localparam logic [3:0] SRC_ZERO  = 4'd10;

    // Bit positions inside reg_en = {o_reg, dm, i, m, r, y1, y0, x1, x0}
    localparam int unsigned REG_X0 = 0;
    localparam int unsigned REG_X1 = 1;
    localparam int unsigned REG_Y0 = 2;
    localparam int unsigned REG_Y1 = 3;
    localparam int unsigned REG_R  = 4;
    localparam int unsigned REG_M  = 5;
    localparam int unsigned REG_I  = 6;
    localparam int unsigned REG_DM = 7;
    localparam int unsigned REG_O  = 8;

    localparam logic [8:0] REG_EN_ALL  = 9'h1FF;
    localparam logic [8:0] REG_EN_NONE = 9'h000;

    // ALU-class words that leave all architectural state untouched
    localparam logic [7:0] NOP_C8 = 8'hC8;
    localparam logic [7:0] NOP_CF = 8'hCF;
    localparam logic [7:0] NOP_D8 = 8'hD8;
    localparam logic [7:0] NOP_DF = 8'hDF;

    function automatic instr_class_e classify(input logic [7:0] w);
        instr_class_e c;
        casez (w)
            8'b0???_????: c = CLS_LOAD;
            8'b10??_????: c = CLS_MOVE;
            8'b110?_????: c = CLS_ALU;
            8'b1110_????: c = CLS_JMP;
            default:      c = CLS_JMP_NZ;
        endcase
        return c;
    endfunction

    // Destination field to one-hot enable; d=4 addresses o_reg, not r
    function automatic logic [8:0] dest_onehot(input logic [2:0] d);
        logic [8:0] oh;
        oh = REG_EN_NONE;
        if (d == 3'd4) begin
            oh[REG_O] = 1'b1;
        end else begin
            oh[d] = 1'b1;
        end
        return oh;
    endfunction

    function automatic logic nop_word(input logic [7:0] w);
        return (w == NOP_C8) || (w == NOP_CF) || (w == NOP_D8) || (w == NOP_DF);
    endfunction

endpackage

// File: rtl/instruction_decoder_pipe_if.sv
// Fetch handshake, downstream control and decoded-output bundle of the decoder.
interface instruction_decoder_pipe_if #(
    parameter int unsigned CNT_W = 16
);
    logic [7:0]       next_instr;
    logic             instr_valid;
    logic             instr_ready;
    logic             stall;
    logic             zero_flag;
    logic             nop_clr;
    logic [7:0]       ir;
    logic [3:0]       ir_nibble;
    logic             dec_valid;
    logic [8:0]       reg_en;
    logic [7:0]       from_ID;
    logic [3:0]       source_sel;
    logic             i_sel;
    logic             x_sel;
    logic             y_sel;
    logic             jmp;
    logic             jmp_nz;
    logic             jmp_taken;
    logic             flush;
    logic [CNT_W-1:0] nop_count;

    // Fetch/PC side and downstream consumers
    modport master (
        output next_instr, instr_valid, stall, zero_flag, nop_clr,
        input  instr_ready, ir, ir_nibble, dec_valid, reg_en, from_ID, source_sel,
               i_sel, x_sel, y_sel, jmp, jmp_nz, jmp_taken, flush, nop_count
    );

    // Decoder side
    modport slave (
        input  next_instr, instr_valid, stall, zero_flag, nop_clr,
        output instr_ready, ir, ir_nibble, dec_valid, reg_en, from_ID, source_sel,
               i_sel, x_sel, y_sel, jmp, jmp_nz, jmp_taken, flush, nop_count
    );
endinterface

// File: rtl/instruction_decoder_pipe_decode.sv
// Pure combinational decode of the instruction register: raw (ungated)
// register enables, bus source select, operand selects and class flags.
module instr_decode_comb
    import instruction_decoder_pipe_pkg::*;
(
    input  logic [7:0] ir,
    output logic [8:0] reg_en,
    output logic [3:0] source_sel,
    output logic       i_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic       is_jmp,
    output logic       is_jmp_nz,
    output logic       is_nop
);
    instr_class_e cls_s;
    logic [2:0]   dst_s;
    logic [2:0]   src_s;

    assign cls_s  = classify(ir);
    assign src_s  = ir[2:0];
    assign is_nop = nop_word(ir);

    // Per-class field extraction and enable/select generation
    always_comb begin
        reg_en     = REG_EN_NONE;
        source_sel = {1'b0, ir[2:0]};
        i_sel      = 1'b1;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        is_jmp     = 1'b0;
        is_jmp_nz  = 1'b0;
        dst_s      = 3'd0;
        case (cls_s)
            CLS_LOAD: begin
                dst_s  = ir[6:4];
                reg_en = dest_onehot(dst_s);
                if (dst_s == 3'd7) begin
                    reg_en[REG_I] = 1'b1;
                end else begin
                    reg_en[REG_I] = reg_en[REG_I];
                end
                source_sel = SRC_IMM;
                i_sel      = (dst_s != 3'd6);
            end
            CLS_MOVE: begin
                dst_s  = ir[5:3];
                reg_en = dest_onehot(dst_s);
                if ((dst_s == 3'd7) || (src_s == 3'd7)) begin
                    reg_en[REG_I] = 1'b1;
                end else begin
                    reg_en[REG_I] = reg_en[REG_I];
                end
                // s=4 reads r; s=d (a self-move) reads the input pins instead
                if (src_s == 3'd4) begin
                    source_sel = SRC_R;
                end else if (src_s == dst_s) begin
                    source_sel = SRC_IPINS;
                end else begin
                    source_sel = {1'b0, src_s};
                end
                i_sel = (dst_s != 3'd6);
            end
            CLS_ALU: begin
                reg_en[REG_R] = 1'b1;
                x_sel         = ir[4];
                y_sel         = ir[3];
            end
            CLS_JMP: begin
                is_jmp = 1'b1;
            end
            CLS_JMP_NZ: begin
                is_jmp_nz = 1'b1;
            end
            default: begin
                reg_en = REG_EN_NONE;
            end
        endcase
    end
endmodule

// File: rtl/instruction_decoder_pipe.sv
// Pipelined instruction decoder: one-entry instruction register with a
// valid/ready fetch handshake, stall gating, taken-jump squash of wrong-path
// words and a saturating NOP counter.
module instruction_decoder_pipe
    import instruction_decoder_pipe_pkg::*;
#(
    parameter int unsigned SQUASH = 1,
    parameter int unsigned CNT_W  = 16
)(
    input  logic                     clk,
    input  logic                     sync_reset,
    instruction_decoder_pipe_if.slave bus
);
    localparam logic [3:0] SQ_FULL = 4'(SQUASH);
    // When the taken jump coincides with an accept, that word uses one drop
    localparam logic [3:0] SQ_LESS = (SQ_FULL == 4'd0) ? 4'd0 : (SQ_FULL - 4'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [7:0]       ir_r;
    logic             ir_valid_r;
    logic [3:0]       sq_cnt_r;
    logic [CNT_W-1:0] nop_cnt_r;

    logic       issue_s;
    logic       ready_s;
    logic       accept_s;
    logic       taken_s;
    logic       drop_s;
    logic [8:0] raw_reg_en_s;
    logic [3:0] raw_src_s;
    logic       raw_i_sel_s;
    logic       raw_x_sel_s;
    logic       raw_y_sel_s;
    logic       is_jmp_s;
    logic       is_jmp_nz_s;
    logic       is_nop_s;

    instr_decode_comb u_decode (
        .ir         (ir_r),
        .reg_en     (raw_reg_en_s),
        .source_sel (raw_src_s),
        .i_sel      (raw_i_sel_s),
        .x_sel      (raw_x_sel_s),
        .y_sel      (raw_y_sel_s),
        .is_jmp     (is_jmp_s),
        .is_jmp_nz  (is_jmp_nz_s),
        .is_nop     (is_nop_s)
    );

    assign issue_s  = ir_valid_r & ~bus.stall;
    assign ready_s  = ~sync_reset & (~ir_valid_r | ~bus.stall);
    assign accept_s = bus.instr_valid & ready_s;
    assign taken_s  = issue_s & (is_jmp_s | (is_jmp_nz_s & ~bus.zero_flag));
    assign drop_s   = accept_s & ((sq_cnt_r != 4'd0) | (taken_s & (SQ_FULL != 4'd0)));

    // Instruction register and its valid flag
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            ir_r       <= 8'h00;
            ir_valid_r <= 1'b0;
        end else if (accept_s) begin
            ir_r       <= bus.next_instr;
            ir_valid_r <= ~drop_s;
        end else if (issue_s) begin
            ir_valid_r <= 1'b0;
        end else begin
            ir_valid_r <= ir_valid_r;
        end
    end

    // Wrong-path drop counter armed by a taken jump
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            sq_cnt_r <= 4'd0;
        end else if (taken_s) begin
            sq_cnt_r <= accept_s ? SQ_LESS : SQ_FULL;
        end else if (accept_s && (sq_cnt_r != 4'd0)) begin
            sq_cnt_r <= sq_cnt_r - 4'd1;
        end else begin
            sq_cnt_r <= sq_cnt_r;
        end
    end

    // Saturating count of issued NOPs; clear wins over increment
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            nop_cnt_r <= '0;
        end else if (bus.nop_clr) begin
            nop_cnt_r <= '0;
        end else if (issue_s && is_nop_s && !(&nop_cnt_r)) begin
            nop_cnt_r <= nop_cnt_r + CNT_ONE;
        end else begin
            nop_cnt_r <= nop_cnt_r;
        end
    end

    // Issue gating of decoded outputs; reset forces a zero-load of every register
    always_comb begin
        bus.instr_ready = ready_s;
        bus.ir          = ir_r;
        bus.ir_nibble   = ir_r[3:0];
        bus.nop_count   = nop_cnt_r;
        if (sync_reset) begin
            bus.dec_valid  = 1'b0;
            bus.reg_en     = REG_EN_ALL;
            bus.source_sel = SRC_ZERO;
            bus.i_sel      = 1'b0;
            bus.x_sel      = 1'b0;
            bus.y_sel      = 1'b0;
            bus.jmp        = 1'b0;
            bus.jmp_nz     = 1'b0;
            bus.jmp_taken  = 1'b0;
            bus.flush      = 1'b0;
        end else begin
            bus.dec_valid  = issue_s;
            bus.reg_en     = issue_s ? raw_reg_en_s : REG_EN_NONE;
            bus.source_sel = raw_src_s;
            bus.i_sel      = raw_i_sel_s;
            bus.x_sel      = raw_x_sel_s;
            bus.y_sel      = raw_y_sel_s;
            bus.jmp        = issue_s & is_jmp_s;
            bus.jmp_nz     = issue_s & is_jmp_nz_s;
            bus.jmp_taken  = taken_s;
            bus.flush      = taken_s;
        end
        bus.from_ID = bus.reg_en[7:0];
    end
endmodule

// File: tb/tb_instruction_decoder_pipe.sv
// Self-checking bench: two decoders (SQUASH=1/CNT_W=16 and SQUASH=2/CNT_W=2)
// share identical stimulus and are compared every cycle with a behavioural model.
module tb_instruction_decoder_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_decoder_pipe_if #(.CNT_W(16)) if_a ();
    instruction_decoder_pipe_if #(.CNT_W(2))  if_b ();

    instruction_decoder_pipe #(.SQUASH(1), .CNT_W(16)) dut_a (
        .clk(clk), .sync_reset(rst), .bus(if_a)
    );
    instruction_decoder_pipe #(.SQUASH(2), .CNT_W(2)) dut_b (
        .clk(clk), .sync_reset(rst), .bus(if_b)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [8:0] re;
        logic [3:0] src;
        logic       isel, xsel, ysel, ij, inz, inop;
    } dec_t;

    typedef struct {
        logic        rdy;
        logic [7:0]  ir;
        logic [3:0]  nib;
        logic        dv;
        logic [8:0]  re;
        logic [7:0]  fid;
        logic [3:0]  src;
        logic        isel, xsel, ysel, j, jnz, jt, fl;
        logic [15:0] nop;
    } obs_t;

    // Model state per decoder instance
    logic [7:0] m_ir    [2];
    logic       m_valid [2];
    int         m_drops [2];
    int         m_nop   [2];
    int         sq_param[2] = '{1, 2};
    int         cnt_max [2] = '{65535, 3};
    obs_t       obs     [2];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Instruction semantics written from the opcode table with plain arithmetic
    function automatic dec_t model_decode(input logic [7:0] w);
        dec_t r;
        int v, d, s;
        v = int'(w);
        r.re = 9'h000; r.src = 4'(v % 8); r.isel = 1'b1; r.xsel = 1'b0; r.ysel = 1'b0;
        r.ij = 1'b0; r.inz = 1'b0; r.inop = 1'b0;
        if (v < 128) begin
            d = (v / 16) % 8;
            r.re = (d == 4) ? 9'h100 : 9'(1 << d);
            if (d == 7) r.re = r.re | 9'h040;
            r.src = 4'd8;
            r.isel = (d != 6);
        end else if (v < 192) begin
            d = (v / 8) % 8;
            s = v % 8;
            r.re = (d == 4) ? 9'h100 : 9'(1 << d);
            if (d == 7 || s == 7) r.re = r.re | 9'h040;
            r.src = (s == 4) ? 4'd4 : ((s == d) ? 4'd9 : 4'(s));
            r.isel = (d != 6);
        end else if (v < 224) begin
            r.re = 9'h010;
            r.xsel = 1'((v / 16) % 2);
            r.ysel = 1'((v / 8) % 2);
            r.inop = (v == 200 || v == 207 || v == 216 || v == 223);
        end else if (v < 240) begin
            r.ij = 1'b1;
        end else begin
            r.inz = 1'b1;
        end
        return r;
    endfunction

    function automatic obs_t model_out(input int k, input logic r, input logic s, input logic z);
        obs_t e;
        dec_t d;
        logic iss;
        d = model_decode(m_ir[k]);
        if (r) begin
            e.rdy = 1'b0; e.ir = 8'h00; e.nib = 4'h0; e.dv = 1'b0; e.re = 9'h1FF; e.fid = 8'hFF;
            e.src = 4'd10; e.isel = 1'b0; e.xsel = 1'b0; e.ysel = 1'b0; e.j = 1'b0; e.jnz = 1'b0;
            e.jt = 1'b0; e.fl = 1'b0; e.nop = 16'd0;
        end else begin
            iss   = m_valid[k] && !s;
            e.rdy = !m_valid[k] || !s;
            e.ir  = m_ir[k];
            e.nib = m_ir[k][3:0];
            e.dv  = iss;
            e.re  = iss ? d.re : 9'h000;
            e.fid = e.re[7:0];
            e.src = d.src; e.isel = d.isel; e.xsel = d.xsel; e.ysel = d.ysel;
            e.j   = iss && d.ij;
            e.jnz = iss && d.inz;
            e.jt  = iss && (d.ij || (d.inz && !z));
            e.fl  = e.jt;
            e.nop = 16'(m_nop[k]);
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ir[k] = 8'h00; m_valid[k] = 1'b0; m_drops[k] = 0; m_nop[k] = 0;
        end
    endtask

    // Advance the model by one clock edge
    task automatic model_step(input int k, input logic [7:0] w, input logic v, input logic s,
                              input logic z, input logic c, input logic r);
        dec_t d;
        logic iss, rdy, acc, taken;
        if (r) begin
            m_ir[k] = 8'h00; m_valid[k] = 1'b0; m_drops[k] = 0; m_nop[k] = 0;
        end else begin
            d     = model_decode(m_ir[k]);
            iss   = m_valid[k] && !s;
            rdy   = !m_valid[k] || !s;
            acc   = v && rdy;
            taken = iss && (d.ij || (d.inz && !z));
            if (taken) m_drops[k] = sq_param[k];
            if (c) m_nop[k] = 0;
            else if (iss && d.inop && m_nop[k] < cnt_max[k]) m_nop[k] = m_nop[k] + 1;
            if (acc) begin
                m_ir[k] = w;
                if (m_drops[k] > 0) begin
                    m_drops[k] = m_drops[k] - 1;
                    m_valid[k] = 1'b0;
                end else begin
                    m_valid[k] = 1'b1;
                end
            end else if (iss) begin
                m_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic [7:0] w, input logic v, input logic s, input logic z, input logic c);
        if_a.next_instr = w; if_a.instr_valid = v; if_a.stall = s; if_a.zero_flag = z; if_a.nop_clr = c;
        if_b.next_instr = w; if_b.instr_valid = v; if_b.stall = s; if_b.zero_flag = z; if_b.nop_clr = c;
    endtask

    task automatic sample();
        obs[0].rdy = if_a.instr_ready; obs[0].ir = if_a.ir; obs[0].nib = if_a.ir_nibble;
        obs[0].dv = if_a.dec_valid; obs[0].re = if_a.reg_en; obs[0].fid = if_a.from_ID;
        obs[0].src = if_a.source_sel; obs[0].isel = if_a.i_sel; obs[0].xsel = if_a.x_sel;
        obs[0].ysel = if_a.y_sel; obs[0].j = if_a.jmp; obs[0].jnz = if_a.jmp_nz;
        obs[0].jt = if_a.jmp_taken; obs[0].fl = if_a.flush; obs[0].nop = if_a.nop_count;
        obs[1].rdy = if_b.instr_ready; obs[1].ir = if_b.ir; obs[1].nib = if_b.ir_nibble;
        obs[1].dv = if_b.dec_valid; obs[1].re = if_b.reg_en; obs[1].fid = if_b.from_ID;
        obs[1].src = if_b.source_sel; obs[1].isel = if_b.i_sel; obs[1].xsel = if_b.x_sel;
        obs[1].ysel = if_b.y_sel; obs[1].j = if_b.jmp; obs[1].jnz = if_b.jmp_nz;
        obs[1].jt = if_b.jmp_taken; obs[1].fl = if_b.flush; obs[1].nop = {14'd0, if_b.nop_count};
    endtask

    task automatic compare(input int k, input obs_t e);
        chk($sformatf("ready_%0d", k),   32'(obs[k].rdy),  32'(e.rdy));
        chk($sformatf("ir_%0d", k),      32'(obs[k].ir),   32'(e.ir));
        chk($sformatf("nibble_%0d", k),  32'(obs[k].nib),  32'(e.nib));
        chk($sformatf("dec_valid_%0d", k), 32'(obs[k].dv), 32'(e.dv));
        chk($sformatf("reg_en_%0d", k),  32'(obs[k].re),   32'(e.re));
        chk($sformatf("from_id_%0d", k), 32'(obs[k].fid),  32'(e.fid));
        chk($sformatf("src_%0d", k),     32'(obs[k].src),  32'(e.src));
        chk($sformatf("i_sel_%0d", k),   32'(obs[k].isel), 32'(e.isel));
        chk($sformatf("x_sel_%0d", k),   32'(obs[k].xsel), 32'(e.xsel));
        chk($sformatf("y_sel_%0d", k),   32'(obs[k].ysel), 32'(e.ysel));
        chk($sformatf("jmp_%0d", k),     32'(obs[k].j),    32'(e.j));
        chk($sformatf("jmp_nz_%0d", k),  32'(obs[k].jnz),  32'(e.jnz));
        chk($sformatf("taken_%0d", k),   32'(obs[k].jt),   32'(e.jt));
        chk($sformatf("flush_%0d", k),   32'(obs[k].fl),   32'(e.fl));
        chk($sformatf("nop_cnt_%0d", k), 32'(obs[k].nop),  32'(e.nop));
    endtask

    // One clock: drive at edge+1, check at the falling edge, then step the model
    task automatic cycle(input logic [7:0] w, input logic v, input logic s, input logic z, input logic c);
        drive(w, v, s, z, c);
        @(negedge clk);
        sample();
        for (int k = 0; k < 2; k++) begin
            compare(k, model_out(k, rst, s, z));
            model_step(k, w, v, s, z, c, rst);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cycle(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_reg_en", 32'(obs[0].re), 32'h1FF);
        chk("rst_src", 32'(obs[0].src), 32'd10);
        chk("rst_ready", 32'(obs[0].rdy), 32'd0);
        rst = 1'b0;

        // Load / move decoding
        cycle(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'h15, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("load07_reg_en", 32'(obs[0].re), 32'h001);
        chk("load07_src", 32'(obs[0].src), 32'd8);
        chk("load07_nibble", 32'(obs[0].nib), 32'h7);
        cycle(8'h9B, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("load15_reg_en", 32'(obs[0].re), 32'h002);
        chk("load15_nibble", 32'(obs[0].nib), 32'h5);
        cycle(8'hBC, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("move9b_reg_en", 32'(obs[0].re), 32'h008);
        chk("move9b_src", 32'(obs[0].src), 32'd9);
        cycle(8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("movebc_reg_en", 32'(obs[0].re), 32'h0C0);
        chk("movebc_src", 32'(obs[0].src), 32'd4);

        // Stall holds ir=20 with no writes and no acceptance
        for (int i = 0; i < 3; i++) begin
            cycle(8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("stall_ir", 32'(obs[0].ir), 32'h20);
            chk("stall_reg_en", 32'(obs[0].re), 32'h000);
            chk("stall_ready", 32'(obs[0].rdy), 32'd0);
        end
        cycle(8'hE5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("release_reg_en", 32'(obs[0].re), 32'h004);

        // Taken jump squashes the next word (two words on the SQUASH=2 instance)
        cycle(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("jmp_flush_a", 32'(obs[0].fl), 32'd1);
        chk("jmp_flush_b", 32'(obs[1].fl), 32'd1);
        cycle(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_once", 32'(obs[0].fl), 32'd0);
        chk("dropped_11", 32'(obs[0].dv), 32'd0);
        cycle(8'hF5, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("after_sq_reg_en", 32'(obs[0].re), 32'h004);
        cycle(8'h31, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("jnz_zero_flush", 32'(obs[0].fl), 32'd0);
        chk("jnz_zero_issue", 32'(obs[0].dv), 32'd1);

        // NOP counting and saturation
        cycle(8'hC8, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(8'hCF, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'hD8, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'hDF, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'hC9, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'hC8, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("nop4_a", 32'(obs[0].nop), 32'd4);
        chk("nop4_sat_b", 32'(obs[1].nop), 32'd3);
        cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nop5_a", 32'(obs[0].nop), 32'd5);
        chk("nop5_sat_b", 32'(obs[1].nop), 32'd3);
        cycle(8'hCF, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nop_clr_prio", 32'(obs[0].nop), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset in the middle of a squash window
        for (int i = 0; i < 4; i++) cycle(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(8'hE0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reg_en_a", 32'(if_a.reg_en), 32'h1FF);
        chk("async_reg_en_b", 32'(if_b.reg_en), 32'h1FF);
        chk("async_src_b", 32'(if_b.source_sel), 32'd10);
        chk("async_ready_b", 32'(if_b.instr_ready), 32'd0);
        model_reset();
        cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cycle(8'h23, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_issue_b", 32'(obs[1].dv), 32'd1);
        chk("post_rst_reg_en_b", 32'(obs[1].re), 32'h004);
        chk("post_rst_reg_en_a", 32'(obs[0].re), 32'h004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
